// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_pkg
// Purpose  : Shared defaults and sizing helpers for the pipelined adder.
// Revision : 1.0
// ============================================================================
package adder_pkg;

    localparam int c_DEFAULT_WIDTH  = 32;
    localparam int c_DEFAULT_STAGES = 4;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Operand-B bits still waiting to be consumed are packed back to back,
    // stage k owning (width - (k+1)*chunk) bits; this returns where stage k starts.
    function automatic int bpipe_offset(input int width, input int chunk, input int k);
        return k * width - (chunk * k * (k + 1)) / 2;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/adder_stage.sv
`default_nettype none
// ============================================================================
// Module   : adder_stage
// Purpose  : One CHUNK-bit slice of the pipelined adder with valid/ready hold.
// Revision : 1.0
// ============================================================================
module adder_stage #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] word_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] word_o,
    output logic             carry_o
);

    localparam int c_LO = IDX * CHUNK;

    logic             valid_q;
    logic             valid_d;
    logic             carry_q;
    logic             carry_d;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    logic             w_ready;
    logic             w_load;
    logic [CHUNK:0]   w_chunk_sum;

    assign w_ready     = !valid_q || ready_i;
    assign w_load      = valid_i && w_ready;
    assign w_chunk_sum = {1'b0, word_i[c_LO +: CHUNK]} + {1'b0, b_i} + {{CHUNK{1'b0}}, carry_i};

    // The word holds finished sum bits below this chunk and raw operand A above it.
    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        word_d  = word_q;
        if (w_ready) begin
            valid_d = valid_i;
        end
        if (w_load) begin
            word_d               = word_i;
            word_d[c_LO +: CHUNK] = w_chunk_sum[CHUNK-1:0];
            carry_d              = w_chunk_sum[CHUNK];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            valid_q <= 1'b0;
            carry_q <= 1'b0;
            word_q  <= '0;
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            word_q  <= word_d;
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign carry_o = carry_q;

endmodule : adder_stage
`default_nettype wire

// File: rtl/pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_adder
// Purpose  : STAGES-deep ripple-by-chunk adder with elastic valid/ready flow.
//            Define ADDER_OVERFLOW_EN to add the signed 'overflow' output.
//            Requires STAGES >= 2 and WIDTH % STAGES == 0.
// Revision : 1.0
// ============================================================================
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int STAGES = c_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] sum,
    output logic             cOut
`ifdef ADDER_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int c_CHUNK   = chunk_width(WIDTH, STAGES);
    localparam int c_BPIPE_W = bpipe_offset(WIDTH, c_CHUNK, STAGES - 1);
`ifdef ADDER_OVERFLOW_EN
    localparam int c_ACC_N   = STAGES;
`else
    localparam int c_ACC_N   = STAGES - 1;
`endif

    logic [STAGES-1:0]  w_valid_in;
    logic [STAGES-1:0]  w_valid_out;
    logic [STAGES-1:0]  w_carry_in;
    logic [STAGES-1:0]  w_carry_out;
    logic [STAGES-1:0]  w_ready_nxt;
    logic [WIDTH-1:0]   w_word_in  [STAGES];
    logic [WIDTH-1:0]   w_word_out [STAGES];
    logic [c_CHUNK-1:0] w_b_chunk  [STAGES];
    wire  [c_BPIPE_W-1:0] w_bpipe;
    logic [c_ACC_N-1:0] w_accept;

    // Stage k may advance unless every stage from k+1 to the output is full and stalled.
    always_comb begin
        logic w_down_full;
        w_down_full = 1'b1;
        w_ready_nxt = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready_nxt[k] = outReady || !w_down_full;
            w_down_full    = w_down_full && w_valid_out[k];
        end
    end

    always_comb begin
        w_accept = '0;
        for (int k = 0; k < c_ACC_N; k++) begin
            w_accept[k] = w_valid_in[k] && (!w_valid_out[k] || w_ready_nxt[k]);
        end
    end

    assign inReady = !w_valid_out[0] || w_ready_nxt[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_valid_in[k] = inValid;
            assign w_word_in[k]  = in1;
            assign w_b_chunk[k]  = in2[c_CHUNK-1:0];
            assign w_carry_in[k] = cIn;
        end else begin : g_chain
            assign w_valid_in[k] = w_valid_out[k-1];
            assign w_word_in[k]  = w_word_out[k-1];
            assign w_b_chunk[k]  = w_bpipe[bpipe_offset(WIDTH, c_CHUNK, k - 1) +: c_CHUNK];
            assign w_carry_in[k] = w_carry_out[k-1];
        end

        adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (c_CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rstN    (rstN),
            .valid_i (w_valid_in[k]),
            .word_i  (w_word_in[k]),
            .b_i     (w_b_chunk[k]),
            .carry_i (w_carry_in[k]),
            .ready_i (w_ready_nxt[k]),
            .valid_o (w_valid_out[k]),
            .word_o  (w_word_out[k]),
            .carry_o (w_carry_out[k])
        );
    end

    // Unconsumed upper bits of operand B travel alongside the stage that owns them.
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_bpipe
        localparam int c_OFF = bpipe_offset(WIDTH, c_CHUNK, k);
        localparam int c_BW  = WIDTH - (k + 1) * c_CHUNK;

        logic [c_BW-1:0] bseg_q;
        logic [c_BW-1:0] bseg_d;

        if (k == 0) begin : g_src_in
            assign bseg_d = w_accept[k] ? in2[WIDTH-1:c_CHUNK] : bseg_q;
        end else begin : g_src_pipe
            assign bseg_d = w_accept[k]
                          ? w_bpipe[bpipe_offset(WIDTH, c_CHUNK, k - 1) + c_CHUNK +: c_BW]
                          : bseg_q;
        end

        always_ff @(posedge clk or negedge rstN) begin
            if (!rstN) begin
                bseg_q <= '0;
            end else begin
                bseg_q <= bseg_d;
            end
        end

        assign w_bpipe[c_OFF +: c_BW] = bseg_q;
    end

    assign outValid = w_valid_out[STAGES-1];
    assign sum      = w_word_out[STAGES-1];
    assign cOut     = w_carry_out[STAGES-1];

`ifdef ADDER_OVERFLOW_EN
    // Carry into the MSB is recovered as a^b^sum at the MSB, so only a^b rides along.
    logic [STAGES-1:0] msbx_q;
    logic [STAGES-1:0] msbx_d;
    logic [STAGES-1:0] w_msbx_src;

    assign w_msbx_src = {msbx_q[STAGES-2:0], in1[WIDTH-1] ^ in2[WIDTH-1]};

    always_comb begin
        msbx_d = msbx_q;
        for (int k = 0; k < STAGES; k++) begin
            if (w_accept[k]) begin
                msbx_d[k] = w_msbx_src[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            msbx_q <= '0;
        end else begin
            msbx_q <= msbx_d;
        end
    end

    assign overflow = cOut ^ msbx_q[STAGES-1] ^ sum[WIDTH-1];
`endif

endmodule : pipe_adder
`default_nettype wire

// File: tb/tb_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_adder
// Purpose  : Scoreboard bench for pipe_adder (WIDTH=32, STAGES=4).
// Revision : 1.0
// ============================================================================
module tb_pipe_adder;

    localparam int W = 32;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cIn;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] sum;
    logic         cOut;
`ifdef ADDER_OVERFLOW_EN
    logic         overflow;
`endif

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH  (32),
        .STAGES (4)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .in1      (in1),
        .in2      (in2),
        .cIn      (cIn),
        .outValid (outValid),
        .outReady (outReady),
        .sum      (sum),
        .cOut     (cOut)
`ifdef ADDER_OVERFLOW_EN
        ,
        .overflow (overflow)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
        bit           lat;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    // Hand-computed directed vectors
    vec_t vecs [7] = '{
        '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0},
        '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0},
        '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1},
        '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0},
        '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1},
        '{32'h00FF00FF, 32'h00010001, 1'b1, 32'h01000101, 1'b0, 1'b0},
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0}
    };

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t        m;
        logic [W:0]  full;
        logic [W-1:0] low;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        low    = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]} + {{(W-1){1'b0}}, c};
        m.sum  = full[W-1:0];
        m.cout = full[W];
        m.ovf  = low[W-1] ^ full[W];
        m.cyc  = 0;
        m.lat  = 1'b0;
        return m;
    endfunction

    function automatic exp_t from_vec(input vec_t v, input bit lat);
        exp_t e;
        e.sum  = v.s;
        e.cout = v.co;
        e.ovf  = v.ov;
        e.cyc  = 0;
        e.lat  = lat;
        return e;
    endfunction

    // Present one beat, hold until accepted, record expectation. Entered/leaves at posedge+1.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input exp_t e, input bit b2b);
        int waited;
        waited  = 0;
        inValid = 1'b1;
        in1     = a;
        in2     = b;
        cIn     = c;
        @(negedge clk);
        if (b2b) check("b2b_inReady", inReady, 1);
        while (!inReady && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!inReady) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual inReady=0 required=1 within 40 cycles");
        end else begin
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: actual pending=%0d required=0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops one expectation for every result transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (outValid && outReady) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: actual sum=0x%0h required=no result pending", sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", sum, e.sum);
                    check("cOut", cOut, e.cout);
`ifdef ADDER_OVERFLOW_EN
                    check("overflow", overflow, e.ovf);
`endif
                    if (e.lat) check("latency", cyc - e.cyc, LAT);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] held;
        bit           have;
        int           acc;
        int           idx;
        exp_t         e;

        rstN     = 1'b0;
        inValid  = 1'b0;
        in1      = '0;
        in2      = '0;
        cIn      = 1'b0;
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outValid", outValid, 0);
        check("reset_sum", sum, 0);
        check("reset_cOut", cOut, 0);
`ifdef ADDER_OVERFLOW_EN
        check("reset_overflow", overflow, 0);
`endif
        rstN = 1'b1;
        #1;
        check("reset_inReady", inReady, 1);

        // Directed vectors, each checked for exact latency
        foreach (vecs[i]) send(vecs[i].a, vecs[i].b, vecs[i].c, from_vec(vecs[i], 1'b1), 1'b0);
        wait_drain();

        // 100 back-to-back beats with the consumer always ready
        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            e = model(a, b, c);
            e.lat = 1'b1;
            send(a, b, c, e, 1'b1);
        end
        wait_drain();

        // Output stall for 10 cycles: pipeline fills to exactly 4 and holds
        outReady = 1'b0;
        acc  = 0;
        idx  = 0;
        have = 1'b0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            inValid = 1'b1;
            in1     = vecs[idx % 7].a;
            in2     = vecs[idx % 7].b;
            cIn     = vecs[idx % 7].c;
            @(negedge clk);
            if (outValid) begin
                if (!have) begin
                    held = sum;
                    have = 1'b1;
                end else begin
                    check("stall_sum_hold", sum, held);
                end
            end
            if (inReady) begin
                e = from_vec(vecs[idx % 7], 1'b0);
                sb.push_back(e);
                acc++;
                idx++;
            end
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        check("stall_accept_count", acc, 4);
        @(negedge clk);
        check("stall_inReady", inReady, 0);
        check("stall_outValid", outValid, 1);
        check("stall_sum_first", sum, vecs[0].s);
        @(posedge clk);
        #1;
        outReady = 1'b1;
        wait_drain();

        // Reset with three beats in flight
        send(vecs[0].a, vecs[0].b, vecs[0].c, from_vec(vecs[0], 1'b1), 1'b0);
        send(vecs[3].a, vecs[3].b, vecs[3].c, from_vec(vecs[3], 1'b1), 1'b0);
        send(vecs[5].a, vecs[5].b, vecs[5].c, from_vec(vecs[5], 1'b1), 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        check("midreset_outValid", outValid, 0);
        check("midreset_sum", sum, 0);
        check("midreset_cOut", cOut, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        #1;
        check("post_reset_inReady", inReady, 1);
        send(vecs[6].a, vecs[6].b, vecs[6].c, from_vec(vecs[6], 1'b1), 1'b0);
        wait_drain();
        repeat (6) @(posedge clk);
        #1;
        check("final_outValid", outValid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_adder
`default_nettype wire
